fb_writer: RTL and testbench
============================

# fb_writer

Framebuffer write engine between the rasteriser's pixel FIFO and the PLB master IPIF. It pops one 96-bit pixel record at a time and converts the pixel coordinates into a framebuffer byte address. It then issues a single-beat 32-bit write over the IPIF master interface and waits for completion before popping the next record.

## Interface
- FB_BASE_ADDR, 32'h0000_0000: byte address of pixel (0,0).
- FB_WIDTH, 640: pixels per line. Also the x bound.
- FB_HEIGHT, 480: number of lines. Also the y bound.
- PLB_clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- Bus2IP_Reset  in  1  asynchronous, active-high; ORed with reset, identical effect.
- fifo_data  in  [0:95]  pixel record: [0:31] colour (write data), [32:47] y, [48:63] x, [64:95] reserved, ignored.
- fifo_empty  in  1  high when FIFO holds no record.
- fifo_rd_en  out  1  one-cycle pop strobe. Data is valid the cycle after.
- IP2Bus_MstRd_Req  out  1  tied 0.
- IP2Bus_MstWr_Req  out  1  write request.
- IP2Bus_Mst_Addr  out  [0:31]  write byte address.
- IP2Bus_Mst_BE  out  [0:3]  4'b1111 while requesting, else 4'b0000.
- IP2Bus_Mst_Lock  out  1  tied 0.
- IP2Bus_Mst_Reset  out  1  tied 0.
- Bus2IP_Mst_CmdAck  in  1  command accepted.
- Bus2IP_Mst_Cmplt  in  1  transaction complete.
- Bus2IP_Mst_Error  in  1  transaction error (qualifies Cmplt).
- Bus2IP_Mst_Rearbitrate  in  1  request must be dropped and retried.
- Bus2IP_Mst_Cmd_Timeout  in  1  command timed out.
- Bus2IP_MstRd_d  in  [0:31]  unused.
- Bus2IP_MstRd_src_rdy_n  in  1  unused.
- IP2Bus_MstWr_d  out  [0:31]  latched colour.
- Bus2IP_MstWr_dst_rdy_n  in  1  write-data accept, active-low. Data is held regardless.

## Operation
- FSM states: IDLE, POP, LATCH, REQ, WAIT_CMPLT, BACKOFF. All outputs are Moore (registered state decode).
- IDLE: if fifo_empty==0, go to POP. Otherwise stay.
- POP: fifo_rd_en=1 for exactly this cycle. Always go to LATCH.
- LATCH: register colour, x and y from fifo_data.
  - Compute addr = FB_BASE_ADDR + ((y*FB_WIDTH + x) << 2), 32-bit, wrapping mod 2^32.
  - If x>=FB_WIDTH or y>=FB_HEIGHT, drop the record: go to IDLE with no bus activity.
  - Otherwise go to REQ.
- REQ: IP2Bus_MstWr_Req=1, Addr=latched addr, BE=1111, MstWr_d=colour.
  - Priority order: Cmd_Timeout → IDLE (pixel dropped). Rearbitrate → BACKOFF. CmdAck with Cmplt in the same cycle → IDLE. CmdAck alone → WAIT_CMPLT.
- WAIT_CMPLT: Req=0, addr and data held. Cmplt → IDLE, whether or not Error is set; errored pixels are not retried. Cmd_Timeout → IDLE.
- BACKOFF: Req=0 for one cycle, then REQ with the same address and data.
- The FSM never pops while a transaction is outstanding. At most one record is in flight.
- fifo_empty is sampled only in IDLE. Changes in other states are ignored.
- Unused read-path inputs have no effect.

## Timing
- Reset (either source, asynchronous): state=IDLE, fifo_rd_en=0, MstWr_Req=0, Addr=0, BE=0, MstWr_d=0. Constant outputs are 0.
- Reset mid-transaction: the request drops immediately. The latched pixel is lost. Leaving reset starts in IDLE.
- Pop latency: fifo_empty low at edge k → fifo_rd_en high in cycle k+1 → data captured at edge k+2 → Req high from cycle k+2 (after edge k+2) until the CmdAck edge.
- Minimum record period, with ack and complete in one cycle: 4 cycles, i.e. IDLE, POP, LATCH, REQ.
- Req deasserts the cycle after CmdAck is sampled.
- Addr and MstWr_d stay stable from REQ entry until return to IDLE.
- Address multiply: 16-bit y × parameter width. The product is truncated to 32 bits before the add.

## Test plan
- Reset asserted with fifo_empty=0 → fifo_rd_en=0 and Req=0 throughout reset. First fifo_rd_en pulse comes 1 cycle after the first post-reset IDLE cycle.
- Record colour=32'h00FF00AA, y=2, x=5, defaults; CmdAck and Cmplt both high for one cycle at the third REQ cycle → Addr=32'h0000_1414 (2×640+5=1285, ×4), MstWr_d=32'h00FF00AA, BE=1111, back to IDLE the next cycle.
- Record x=640, y=0 → single fifo_rd_en pulse, no Req ever asserted, IDLE after LATCH.
- Rearbitrate during REQ → Req low for exactly 1 cycle, then reasserted with the same Addr and data. Normal completion follows.
- CmdAck in cycle n, Cmplt with Error at n+3 → Req low from n+1, no new fifo_rd_en until IDLE is re-entered, next record popped normally.
- Stream of 3 records with x=0,1,2 and fifo_empty held 0 → exactly 3 pop pulses, each separated by a completed write. Addresses are FB_BASE_ADDR+0, +4, +8.

Source files
------------

// File: rtl/fb_writer.sv
// fb_writer: pops pixel records from the raster FIFO and issues one
// single-beat 32-bit framebuffer write per in-bounds pixel over the IPIF.
module fb_writer #(
    parameter logic [31:0] FB_BASE_ADDR = 32'h0000_0000,
    parameter int          FB_WIDTH     = 640,
    parameter int          FB_HEIGHT    = 480
) (
    input  logic        PLB_clk,
    input  logic        reset,
    input  logic        Bus2IP_Reset,
    input  logic [0:95] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        IP2Bus_MstRd_Req,
    output logic        IP2Bus_MstWr_Req,
    output logic [0:31] IP2Bus_Mst_Addr,
    output logic [0:3]  IP2Bus_Mst_BE,
    output logic        IP2Bus_Mst_Lock,
    output logic        IP2Bus_Mst_Reset,
    input  logic        Bus2IP_Mst_CmdAck,
    input  logic        Bus2IP_Mst_Cmplt,
    input  logic        Bus2IP_Mst_Error,
    input  logic        Bus2IP_Mst_Rearbitrate,
    input  logic        Bus2IP_Mst_Cmd_Timeout,
    input  logic [0:31] Bus2IP_MstRd_d,
    input  logic        Bus2IP_MstRd_src_rdy_n,
    output logic [0:31] IP2Bus_MstWr_d,
    input  logic        Bus2IP_MstWr_dst_rdy_n
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_POP     = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_BACKOFF = 3'd5;

    localparam logic [31:0] LP_W = 32'(FB_WIDTH);
    localparam logic [31:0] LP_H = 32'(FB_HEIGHT);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_data;

    logic        w_rst;
    logic [31:0] w_color;
    logic [15:0] w_y;
    logic [15:0] w_x;
    logic [31:0] w_prod;
    logic [31:0] w_addr;
    logic        w_oob;
    logic        w_unused;

    assign w_rst   = reset | Bus2IP_Reset;
    assign w_color = fifo_data[0:31];
    assign w_y     = fifo_data[32:47];
    assign w_x     = fifo_data[48:63];

    // Product is truncated to 32 bits before the offset add.
    assign w_prod = 32'(w_y) * LP_W;
    assign w_addr = FB_BASE_ADDR + ((w_prod + {16'h0000, w_x}) << 2);
    assign w_oob  = ({16'h0000, w_x} >= LP_W) || ({16'h0000, w_y} >= LP_H);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!fifo_empty) w_next = S_POP;
            end
            S_POP: w_next = S_LATCH;
            S_LATCH: w_next = w_oob ? S_IDLE : S_REQ;
            S_REQ: begin
                if (Bus2IP_Mst_Cmd_Timeout)
                    w_next = S_IDLE;
                else if (Bus2IP_Mst_Rearbitrate)
                    w_next = S_BACKOFF;
                else if (Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt)
                    w_next = S_IDLE;
                else if (Bus2IP_Mst_CmdAck)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (Bus2IP_Mst_Cmplt || Bus2IP_Mst_Cmd_Timeout)
                    w_next = S_IDLE;
            end
            S_BACKOFF: w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PLB_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= S_IDLE;
            r_addr  <= 32'h0000_0000;
            r_data  <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_LATCH) begin
                r_addr <= w_addr;
                r_data <= w_color;
            end
        end
    end

    assign fifo_rd_en       = (r_state == S_POP);
    assign IP2Bus_MstWr_Req = (r_state == S_REQ);
    assign IP2Bus_Mst_BE    = (r_state == S_REQ) ? 4'b1111 : 4'b0000;
    assign IP2Bus_Mst_Addr  = r_addr;
    assign IP2Bus_MstWr_d   = r_data;
    assign IP2Bus_MstRd_Req = 1'b0;
    assign IP2Bus_Mst_Lock  = 1'b0;
    assign IP2Bus_Mst_Reset = 1'b0;

    // Errors, read path and write-data ready have no influence on the FSM.
    assign w_unused = ^{fifo_data[64:95], Bus2IP_Mst_Error,
                        Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n,
                        Bus2IP_MstWr_dst_rdy_n};

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: FIFO model, scripted IPIF responder and a scoreboard of
// expected (address, colour) pairs checked whenever a write is requested.
module tb_fb_writer;

    logic        PLB_clk = 1'b0;
    logic        reset = 1'b1;
    logic        Bus2IP_Reset = 1'b0;
    logic [0:95] fifo_data = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        IP2Bus_MstRd_Req;
    logic        IP2Bus_MstWr_Req;
    logic [0:31] IP2Bus_Mst_Addr;
    logic [0:3]  IP2Bus_Mst_BE;
    logic        IP2Bus_Mst_Lock;
    logic        IP2Bus_Mst_Reset;
    logic        Bus2IP_Mst_CmdAck = 1'b0;
    logic        Bus2IP_Mst_Cmplt = 1'b0;
    logic        Bus2IP_Mst_Error = 1'b0;
    logic        Bus2IP_Mst_Rearbitrate = 1'b0;
    logic        Bus2IP_Mst_Cmd_Timeout = 1'b0;
    logic [0:31] Bus2IP_MstRd_d = 32'hDEAD_BEEF;
    logic        Bus2IP_MstRd_src_rdy_n = 1'b1;
    logic [0:31] IP2Bus_MstWr_d;
    logic        Bus2IP_MstWr_dst_rdy_n = 1'b1;

    fb_writer dut (
        .PLB_clk                (PLB_clk),
        .reset                  (reset),
        .Bus2IP_Reset           (Bus2IP_Reset),
        .fifo_data              (fifo_data),
        .fifo_empty             (fifo_empty),
        .fifo_rd_en             (fifo_rd_en),
        .IP2Bus_MstRd_Req       (IP2Bus_MstRd_Req),
        .IP2Bus_MstWr_Req       (IP2Bus_MstWr_Req),
        .IP2Bus_Mst_Addr        (IP2Bus_Mst_Addr),
        .IP2Bus_Mst_BE          (IP2Bus_Mst_BE),
        .IP2Bus_Mst_Lock        (IP2Bus_Mst_Lock),
        .IP2Bus_Mst_Reset       (IP2Bus_Mst_Reset),
        .Bus2IP_Mst_CmdAck      (Bus2IP_Mst_CmdAck),
        .Bus2IP_Mst_Cmplt       (Bus2IP_Mst_Cmplt),
        .Bus2IP_Mst_Error       (Bus2IP_Mst_Error),
        .Bus2IP_Mst_Rearbitrate (Bus2IP_Mst_Rearbitrate),
        .Bus2IP_Mst_Cmd_Timeout (Bus2IP_Mst_Cmd_Timeout),
        .Bus2IP_MstRd_d         (Bus2IP_MstRd_d),
        .Bus2IP_MstRd_src_rdy_n (Bus2IP_MstRd_src_rdy_n),
        .IP2Bus_MstWr_d         (IP2Bus_MstWr_d),
        .Bus2IP_MstWr_dst_rdy_n (Bus2IP_MstWr_dst_rdy_n)
    );

    always #5 PLB_clk = ~PLB_clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ack_log[$];
    int          pop_cyc[$];

    int n_chk = 0;
    int n_pass = 0;
    int n_spur = 0;

    logic [0:95] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int cyc = 0;
    int req_rises = 0;
    logic prev_req = 1'b0;

    int ack_at = 1;
    int rearb_req = 0;
    int rearb_done = 0;
    int err_req = 0;
    int err_done = 0;
    int to_req = 0;
    int to_done = 0;
    int wait_cnt = 0;
    int req_cyc = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, want);
    endtask

    function automatic logic [31:0] model_addr(input int x, input int y);
        logic [31:0] p;
        p = 32'(y) * 32'd640;
        return 32'h0000_0000 + ((p + 32'(x)) << 2);
    endfunction

    task automatic push(input logic [31:0] col, input int x, input int y);
        logic [0:95] rec;
        exp_t e;
        rec[0:31]  = col;
        rec[32:47] = 16'(y);
        rec[48:63] = 16'(x);
        rec[64:95] = $urandom;
        if (x < 640 && y < 480) begin
            e.a = model_addr(x, y);
            e.d = col;
            sb.push_back(e);
        end
        mem[wr_ptr % 64] = rec;
        wr_ptr = wr_ptr + 1;
    endtask

    always @(posedge PLB_clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
            pop_cnt   <= pop_cnt + 1;
            pop_cyc.push_back(cyc);
        end
    end

    always begin
        @(posedge PLB_clk);
        #1;
        Bus2IP_Mst_CmdAck      = 1'b0;
        Bus2IP_Mst_Cmplt       = 1'b0;
        Bus2IP_Mst_Error       = 1'b0;
        Bus2IP_Mst_Rearbitrate = 1'b0;
        Bus2IP_Mst_Cmd_Timeout = 1'b0;
        if (wait_cnt > 0) begin
            wait_cnt = wait_cnt - 1;
            if (wait_cnt == 0) begin
                Bus2IP_Mst_Cmplt = 1'b1;
                Bus2IP_Mst_Error = 1'b1;
            end
        end else if (IP2Bus_MstWr_Req) begin
            req_cyc = req_cyc + 1;
            if (to_req != to_done) begin
                Bus2IP_Mst_Cmd_Timeout = 1'b1;
                to_done = to_done + 1;
                req_cyc = 0;
            end else if (rearb_req != rearb_done) begin
                Bus2IP_Mst_Rearbitrate = 1'b1;
                rearb_done = rearb_done + 1;
                req_cyc = 0;
            end else if (req_cyc >= ack_at) begin
                Bus2IP_Mst_CmdAck = 1'b1;
                req_cyc = 0;
                if (err_req != err_done) begin
                    err_done = err_done + 1;
                    wait_cnt = 3;
                end else begin
                    Bus2IP_Mst_Cmplt = 1'b1;
                end
            end
        end
    end

    always @(negedge PLB_clk) begin
        if (!(reset || Bus2IP_Reset)) begin
            if (IP2Bus_MstWr_Req) begin
                if (!prev_req) req_rises = req_rises + 1;
                if (sb.size() == 0) begin
                    n_spur = n_spur + 1;
                end else begin
                    chk("req_addr", IP2Bus_Mst_Addr, sb[0].a);
                    chk("req_wdata", IP2Bus_MstWr_d, sb[0].d);
                    chk("req_be", 32'(IP2Bus_Mst_BE), 32'hF);
                    if (Bus2IP_Mst_CmdAck || Bus2IP_Mst_Cmd_Timeout)
                        void'(sb.pop_front());
                end
                if (Bus2IP_Mst_CmdAck) ack_log.push_back(IP2Bus_Mst_Addr);
            end else begin
                chk("be_idle", 32'(IP2Bus_Mst_BE), 32'h0);
            end
            prev_req = IP2Bus_MstWr_Req;
        end
    end

    task automatic wait_quiet();
        int streak;
        logic ok;
        streak = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge PLB_clk);
            if (fifo_empty && !IP2Bus_MstWr_Req && !fifo_rd_en &&
                wait_cnt == 0 && sb.size() == 0)
                streak++;
            else
                streak = 0;
            if (streak >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("quiet_bound", 32'(ok), 32'h1);
    endtask

    task automatic wait_ack(input string tag, output int reqs);
        logic seen;
        seen = 1'b0;
        reqs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PLB_clk);
            if (IP2Bus_MstWr_Req) reqs++;
            if (IP2Bus_MstWr_Req && Bus2IP_Mst_CmdAck) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'h1);
    endtask

    task automatic sync();
        @(posedge PLB_clk);
        #1;
    endtask

    initial begin
        int p0;
        int r0;
        int nreq;
        int a0;
        logic seen;

        push(32'h1234_5678, 3, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge PLB_clk);
            chk("rst_ctl", {26'd0, fifo_rd_en, IP2Bus_MstWr_Req,
                IP2Bus_MstRd_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset,
                |IP2Bus_Mst_BE}, 32'h0);
            chk("rst_addr", IP2Bus_Mst_Addr, 32'h0);
            chk("rst_wdata", IP2Bus_MstWr_d, 32'h0);
            if (i == 1) begin
                sync();
                reset = 1'b0;
                Bus2IP_Reset = 1'b1;
            end
        end
        sync();
        Bus2IP_Reset = 1'b0;
        @(negedge PLB_clk);
        chk("post_rst_idle", 32'(fifo_rd_en), 32'h0);
        @(negedge PLB_clk);
        chk("first_pop", 32'(fifo_rd_en), 32'h1);
        wait_quiet();

        sync();
        ack_at = 3;
        push(32'h00FF_00AA, 5, 2);
        wait_ack("ex_ack", nreq);
        chk("ex_req_cycles", 32'(nreq), 32'd3);
        chk("ex_addr", IP2Bus_Mst_Addr, 32'h0000_1414);
        chk("ex_wdata", IP2Bus_MstWr_d, 32'h00FF_00AA);
        @(negedge PLB_clk);
        chk("ex_req_drop", 32'(IP2Bus_MstWr_Req), 32'h0);
        wait_quiet();

        sync();
        ack_at = 1;
        p0 = pop_cnt;
        r0 = req_rises;
        push(32'hAAAA_0001, 640, 0);
        push(32'hAAAA_0002, 0, 480);
        wait_quiet();
        chk("oob_pops", 32'(pop_cnt - p0), 32'd2);
        chk("oob_reqs", 32'(req_rises - r0), 32'd0);

        sync();
        rearb_req = rearb_req + 1;
        push(32'hC0FF_EE00, 639, 479);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PLB_clk);
            if (IP2Bus_MstWr_Req && Bus2IP_Mst_Rearbitrate) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rearb_seen", 32'(seen), 32'h1);
        @(negedge PLB_clk);
        chk("rearb_backoff", 32'(IP2Bus_MstWr_Req), 32'h0);
        @(negedge PLB_clk);
        chk("rearb_retry", 32'(IP2Bus_MstWr_Req), 32'h1);
        wait_quiet();
        chk("rearb_addr", ack_log[ack_log.size() - 1], 32'h0012_BFFC);

        sync();
        err_req = err_req + 1;
        p0 = pop_cnt;
        push(32'h0BAD_0001, 10, 10);
        push(32'h600D_0002, 11, 10);
        wait_ack("err_ack", nreq);
        for (int k = 1; k <= 3; k++) begin
            @(negedge PLB_clk);
            chk("err_wait_req", 32'(IP2Bus_MstWr_Req), 32'h0);
            chk("err_wait_pop", 32'(fifo_rd_en), 32'h0);
        end
        @(negedge PLB_clk);
        chk("err_idle_pop", 32'(fifo_rd_en), 32'h0);
        @(negedge PLB_clk);
        chk("err_next_pop", 32'(fifo_rd_en), 32'h1);
        wait_quiet();
        chk("err_pops", 32'(pop_cnt - p0), 32'd2);

        sync();
        to_req = to_req + 1;
        r0 = req_rises;
        push(32'h7100_0001, 20, 3);
        push(32'h7100_0002, 21, 3);
        wait_quiet();
        chk("to_reqs", 32'(req_rises - r0), 32'd2);

        sync();
        p0 = pop_cnt;
        a0 = ack_log.size();
        push(32'h5000_0000, 0, 0);
        push(32'h5000_0001, 1, 0);
        push(32'h5000_0002, 2, 0);
        wait_quiet();
        chk("str_pops", 32'(pop_cnt - p0), 32'd3);
        chk("str_acks", 32'(ack_log.size() - a0), 32'd3);
        if (ack_log.size() - a0 == 3) begin
            chk("str_a0", ack_log[a0], 32'h0);
            chk("str_a1", ack_log[a0 + 1], 32'h4);
            chk("str_a2", ack_log[a0 + 2], 32'h8);
        end
        if (pop_cyc.size() >= 3) begin
            chk("str_gap1", 32'(pop_cyc[pop_cyc.size() - 2] -
                pop_cyc[pop_cyc.size() - 3]), 32'd4);
            chk("str_gap2", 32'(pop_cyc[pop_cyc.size() - 1] -
                pop_cyc[pop_cyc.size() - 2]), 32'd4);
        end

        chk("spurious_reqs", 32'(n_spur), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", n_chk);
        $fatal(1);
    end

endmodule
